// File: rtl/p4_adder_pkg.sv
// p4_adder_pkg: shared widths, data type and request/response structs for the P4 adder pipeline
package p4_adder_pkg;
  localparam int NBIT_DEF = 32;
  localparam int NSTAGES_DEF = 4;
  typedef logic [NBIT_DEF-1:0] data_t;
  typedef struct packed {
    data_t a;
    data_t b;
    logic  cin;
    logic  sub;
  } req_t;
  typedef struct packed {
    data_t s;
    logic  cout;
    logic  ovf;
  } rsp_t;
endpackage

// File: rtl/p4_adder_slice.sv
// p4_adder_slice: one W-bit slice adder with its stage register (valid, partial sum, carry, operands)
module p4_adder_slice
  import p4_adder_pkg::*;
#(
  parameter int NBIT = NBIT_DEF,
  parameter int W    = NBIT_DEF / NSTAGES_DEF,
  parameter int K    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ld_i,
  input  logic            v_i,
  input  logic            c_i,
  input  logic [NBIT-1:0] sum_i,
  input  logic [NBIT-1:0] a_i,
  input  logic [NBIT-1:0] b_i,
  output logic            v_o,
  output logic            c_o,
  output logic [NBIT-1:0] sum_o,
  output logic [NBIT-1:0] a_o,
  output logic [NBIT-1:0] b_o
);
  logic [W:0] r;
  logic [NBIT-1:0] sum_d, sum_q, a_q, b_q;
  logic v_q, c_q;
  always_comb begin
    r = {1'b0, a_i[K*W +: W]} + {1'b0, b_i[K*W +: W]} + {{W{1'b0}}, c_i};
    sum_d = sum_i;
    sum_d[K*W +: W] = r[W-1:0];
  end
  // invalid loads carry zeros so empty stages never expose stale data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q   <= 1'b0;
      c_q   <= 1'b0;
      sum_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (ld_i) begin
      v_q   <= v_i;
      c_q   <= v_i & r[W];
      sum_q <= v_i ? sum_d : '0;
      a_q   <= v_i ? a_i : '0;
      b_q   <= v_i ? b_i : '0;
    end
  assign v_o   = v_q;
  assign c_o   = c_q;
  assign sum_o = sum_q;
  assign a_o   = a_q;
  assign b_o   = b_q;
endmodule

// File: rtl/p4_adder_pipe.sv
// p4_adder_pipe: NSTAGES-deep pipelined add/sub with valid/ready handshakes and bubble collapsing
// Optional signed-overflow output ovf enabled by defining P4_ADDER_PIPE_OVF_EN.
module p4_adder_pipe
  import p4_adder_pkg::*;
#(
  parameter int NBIT    = NBIT_DEF,
  parameter int NSTAGES = NSTAGES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] s,
  output logic            cout
`ifdef P4_ADDER_PIPE_OVF_EN
  ,
  output logic            ovf
`endif
);
  localparam int W = NBIT / NSTAGES;
  if (NSTAGES < 1 || NSTAGES > NBIT || NBIT % NSTAGES != 0) begin : g_cfg_err
    $fatal(1, "p4_adder_pipe: NSTAGES must divide NBIT and lie in 1..NBIT");
  end
  logic [NSTAGES-1:0] adv;
  logic [NSTAGES:0] v_w, c_w;
  logic [NBIT-1:0] sum_w [NSTAGES+1];
  logic [NBIT-1:0] a_w [NSTAGES+1];
  logic [NBIT-1:0] b_w [NSTAGES+1];
  logic unused_ops;
  assign v_w[0]   = in_valid & in_ready;
  assign c_w[0]   = sub | cin;
  assign sum_w[0] = '0;
  assign a_w[0]   = a;
  assign b_w[0]   = sub ? ~b : b;
  for (genvar k = 0; k < NSTAGES; k++) begin : g_st
    // a stage may load when any stage at or below it is empty, or the output drains
    assign adv[k] = out_ready | ~&v_w[NSTAGES:k+1];
    p4_adder_slice #(.NBIT(NBIT), .W(W), .K(k)) u_slice (
      .clk  (clk),
      .rst_n(rst_n),
      .ld_i (adv[k]),
      .v_i  (v_w[k]),
      .c_i  (c_w[k]),
      .sum_i(sum_w[k]),
      .a_i  (a_w[k]),
      .b_i  (b_w[k]),
      .v_o  (v_w[k+1]),
      .c_o  (c_w[k+1]),
      .sum_o(sum_w[k+1]),
      .a_o  (a_w[k+1]),
      .b_o  (b_w[k+1])
    );
  end
  assign in_ready   = adv[0];
  assign out_valid  = v_w[NSTAGES];
  assign s          = sum_w[NSTAGES];
  assign cout       = c_w[NSTAGES];
  assign unused_ops = ^{a_w[NSTAGES], b_w[NSTAGES]};
`ifdef P4_ADDER_PIPE_OVF_EN
  // carry into the MSB recovered from the held operands and sum bit
  assign ovf = a_w[NSTAGES][NBIT-1] ^ b_w[NSTAGES][NBIT-1] ^ s[NBIT-1] ^ cout;
`endif
endmodule

// File: tb/tb_p4_adder_pipe.sv
// tb_p4_adder_pipe: directed + random checks of p4_adder_pipe against an arithmetic reference queue
module tb_p4_adder_pipe;
  import p4_adder_pkg::*;
  localparam int N = NBIT_DEF;
  localparam int S = NSTAGES_DEF;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, cout;
  logic [N-1:0] a = '0, b = '0, s;
`ifdef P4_ADDER_PIPE_OVF_EN
  logic ovf;
`endif
  int checks = 0, errors = 0, run = 0, max_run = 0, n_in = 0, n_out = 0;
  logic held = 1'b0;
  logic [N:0] hold_v;
  rsp_t q[$];

  p4_adder_pipe #(.NBIT(N), .NSTAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout)
`ifdef P4_ADDER_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic rsp_t model(input logic [N-1:0] x, y, input logic ci, sb);
    rsp_t r;
    logic [N:0] t;
    if (sb) begin
      r.s = x - y;
      r.cout = (x >= y);
      r.ovf = (x[N-1] != y[N-1]) && (r.s[N-1] != x[N-1]);
    end else begin
      t = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
      r.s = t[N-1:0];
      r.cout = t[N];
      r.ovf = (x[N-1] == y[N-1]) && (t[N-1] != x[N-1]);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      held = 1'b0;
    end else begin
      if (held) chk("hold_stable", {cout, s}, hold_v);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", out_valid, 0);
        else begin
          chk("s", s, q[0].s);
          chk("cout", cout, q[0].cout);
`ifdef P4_ADDER_PIPE_OVF_EN
          chk("ovf", ovf, q[0].ovf);
`endif
          void'(q.pop_front());
        end
        n_out++;
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      held = out_valid && !out_ready;
      hold_v = {cout, s};
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        n_in++;
      end
    end
  end

  task automatic drain();
    repeat (20 * S + 20) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic single(input logic [N-1:0] x, y, input logic ci, sb,
                        input logic [N-1:0] es, input logic ec, eo);
    int lat;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    repeat (4 * S + 8) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", lat, S);
    chk("single_s", s, es);
    chk("single_cout", cout, ec);
`ifdef P4_ADDER_PIPE_OVF_EN
    chk("single_ovf", ovf, eo);
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation");
`endif
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] first_s;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    single(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      a = N'(i); b = N'(i); cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_run", max_run, 8);
    out_ready = 1'b0;
    max_run = 0;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(negedge clk);
      chk("fill_ready", in_ready, 1);
      tick();
    end
    a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
    first_s = s;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_s", s, first_s);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    drain();
    chk("release_run", max_run, 5);
    single(32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    single(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    single(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    repeat (120) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a = $urandom; b = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("rand_in_out", n_out, n_in);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      chk("flight_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (S - 3) tick();
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_s", s, 0);
    chk("async_rst_cout", cout, 0);
    chk("async_rst_ready", in_ready, 1);
    q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", out_valid, 0);
      tick();
    end
    single(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
